// File: rtl/id_ex_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg_pkg
// Description : Shared widths, opcode constants and FSM encoding for the
//               decode-to-execute pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_reg_pkg;

    localparam int N_DEF   = 16;
    localparam int RA_DEF  = 3;
    localparam int OPC_W   = 5;
    localparam int FUNCT_W = 2;

    localparam logic [OPC_W-1:0] OPC_NOP  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

    // Control bundle: {valid, opCode, funct, regWrite, memRead, memWrite}
    localparam int CTL_W = 1 + OPC_W + FUNCT_W + 3;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_RUN    = 1'b0;
    localparam logic [STATE_W-1:0] ST_HALTED = 1'b1;

    function automatic logic [CTL_W-1:0] bubbleCtl(input logic [OPC_W-1:0] nopOpc);
        return {1'b0, nopOpc, {FUNCT_W{1'b0}}, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_ctl_latch.sv
`default_nettype none
// ============================================================================
// Module      : ex_ctl_latch
// Description : Enable/clear flop bank. Priority: reset > clear > load > hold.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_ctl_latch #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_clear) begin
            r_q <= CLR_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register with stall, flush and HALT freeze.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int               N        = N_DEF,
    parameter int               RA       = RA_DEF,
    parameter logic [OPC_W-1:0] NOP_OPC  = OPC_NOP,
    parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [OPC_W-1:0]   id_opCode,
    input  logic [FUNCT_W-1:0] id_funct,
    input  logic [N-1:0]       id_rd1,
    input  logic [N-1:0]       id_rd2,
    input  logic [N-1:0]       id_imm,
    input  logic [N-1:0]       id_pcInc,
    input  logic [RA-1:0]      id_wrReg,
    input  logic               id_regWrite,
    input  logic               id_memRead,
    input  logic               id_memWrite,
    output logic               ex_valid,
    output logic [OPC_W-1:0]   ex_opCode,
    output logic [FUNCT_W-1:0] ex_funct,
    output logic [N-1:0]       ex_rd1,
    output logic [N-1:0]       ex_rd2,
    output logic [N-1:0]       ex_imm,
    output logic [N-1:0]       ex_pcInc,
    output logic [RA-1:0]      ex_wrReg,
    output logic               ex_regWrite,
    output logic               ex_memRead,
    output logic               ex_memWrite,
    output logic               halted
);

    localparam int               DATA_W      = 4 * N + RA;
    localparam logic [CTL_W-1:0] c_ctlBubble = bubbleCtl(NOP_OPC);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_stateNext;
    logic               w_load;
    logic               w_clear;
    logic [CTL_W-1:0]   w_ctlD;
    logic [CTL_W-1:0]   w_ctlQ;
    logic [DATA_W-1:0]  w_dataD;
    logic [DATA_W-1:0]  w_dataQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_clear = 1'b1;
                end else if (!stall) begin
                    if (id_valid) begin
                        w_load = 1'b1;
                        if (id_opCode == HALT_OPC) begin
                            w_stateNext = ST_HALTED;
                        end
                    end else begin
                        w_clear = 1'b1;
                    end
                end
            end
            // The bubble is a fixed value, so re-clearing every edge emits it
            // once and then holds it, with flush naturally giving the same.
            ST_HALTED: begin
                w_clear = 1'b1;
            end
            default: begin
                w_stateNext = ST_RUN;
            end
        endcase
    end

    assign w_ctlD  = {1'b1, id_opCode, id_funct, id_regWrite, id_memRead, id_memWrite};
    assign w_dataD = {id_rd1, id_rd2, id_imm, id_pcInc, id_wrReg};

    ex_ctl_latch #(
        .W       (CTL_W),
        .RST_VAL (c_ctlBubble),
        .CLR_VAL (c_ctlBubble)
    ) u_ctlLatch (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_d     (w_ctlD),
        .o_q     (w_ctlQ)
    );

    ex_ctl_latch #(
        .W       (DATA_W),
        .RST_VAL ('0),
        .CLR_VAL ('0)
    ) u_dataLatch (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_d     (w_dataD),
        .o_q     (w_dataQ)
    );

    assign {ex_valid, ex_opCode, ex_funct, ex_regWrite, ex_memRead, ex_memWrite} = w_ctlQ;
    assign {ex_rd1, ex_rd2, ex_imm, ex_pcInc, ex_wrReg}                          = w_dataQ;
    assign halted = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Directed vector table plus randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_reg;

    logic        clk;
    logic        rst, stall, flush, id_valid;
    logic [4:0]  id_opCode;
    logic [1:0]  id_funct;
    logic [15:0] id_rd1, id_rd2, id_imm, id_pcInc;
    logic [2:0]  id_wrReg;
    logic        id_regWrite, id_memRead, id_memWrite;
    logic        ex_valid;
    logic [4:0]  ex_opCode;
    logic [1:0]  ex_funct;
    logic [15:0] ex_rd1, ex_rd2, ex_imm, ex_pcInc;
    logic [2:0]  ex_wrReg;
    logic        ex_regWrite, ex_memRead, ex_memWrite;
    logic        halted;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_opCode(id_opCode), .id_funct(id_funct), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_imm(id_imm), .id_pcInc(id_pcInc), .id_wrReg(id_wrReg),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .ex_valid(ex_valid), .ex_opCode(ex_opCode), .ex_funct(ex_funct),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pcInc(ex_pcInc),
        .ex_wrReg(ex_wrReg), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
        .ex_memWrite(ex_memWrite), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  opc;
        logic [1:0]  funct;
        logic [15:0] rd1, rd2, imm, pcInc;
        logic [2:0]  wrReg;
        logic        rw, mr, mw, halted;
    } outs_t;

    // ctl = {rst, stall, flush, valid}; wr = {regWrite, memWrite};
    // eFlg = {ex_valid, ex_regWrite, ex_memWrite, halted}
    typedef struct {
        logic [3:0]  ctl;
        logic [4:0]  opc;
        logic [1:0]  funct;
        logic [15:0] rd1, rd2, imm;
        logic [1:0]  wr;
        logic [3:0]  eFlg;
        logic [4:0]  eOpc;
        logic [1:0]  eFunct;
        logic [15:0] eRd1, eRd2, eImm;
    } vec_t;

    localparam int NVEC = 21;
    vec_t  tbl[NVEC];
    outs_t act, mExp;
    bit    mHalted, mFresh;
    int    nChecks = 0;
    int    nPass   = 0;

    assign act = {ex_valid, ex_opCode, ex_funct, ex_rd1, ex_rd2, ex_imm, ex_pcInc,
                  ex_wrReg, ex_regWrite, ex_memRead, ex_memWrite, halted};

    task automatic check(input string name, input logic [78:0] got, input logic [78:0] want);
        nChecks++;
        if (got === want) nPass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    function automatic outs_t bubble(input bit h);
        outs_t o = '0;
        o.opc    = 5'b00001;
        o.halted = h;
        return o;
    endfunction

    // Reference behaviour written directly from the stage's rules.
    task automatic modelEdge();
        if (rst) begin
            mHalted = 1'b0;
            mFresh  = 1'b0;
            mExp    = bubble(1'b0);
        end else if (mHalted) begin
            if (mFresh || flush) mExp = bubble(1'b1);
            mFresh = 1'b0;
        end else if (flush) begin
            mExp = bubble(1'b0);
        end else if (!stall) begin
            if (id_valid) begin
                mExp = {1'b1, id_opCode, id_funct, id_rd1, id_rd2, id_imm, id_pcInc,
                        id_wrReg, id_regWrite, id_memRead, id_memWrite, 1'b0};
                if (id_opCode == 5'b00000) begin
                    mHalted     = 1'b1;
                    mFresh      = 1'b1;
                    mExp.halted = 1'b1;
                end
            end else begin
                mExp = bubble(1'b0);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        #1;
        check("model", act, mExp);
    endtask

    task automatic randInputs();
        id_opCode   = ($urandom_range(0, 7) == 0) ? 5'b00000 : 5'($urandom);
        id_funct    = 2'($urandom);
        id_rd1      = 16'($urandom);
        id_rd2      = 16'($urandom);
        id_imm      = 16'($urandom);
        id_pcInc    = 16'($urandom);
        id_wrReg    = 3'($urandom);
        id_regWrite = 1'($urandom);
        id_memRead  = 1'($urandom);
        id_memWrite = 1'($urandom);
        id_valid    = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        randInputs();
        mExp = bubble(1'b0); mHalted = 1'b0; mFresh = 1'b0;

        tbl[0]  = '{4'b1001, 5'b11011, 2'b01, 16'h1111, 16'h2222, 16'h3333, 2'b10, 4'b0000, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[1]  = '{4'b1001, 5'b10111, 2'b11, 16'h4444, 16'h5555, 16'h6666, 2'b11, 4'b0000, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[2]  = '{4'b0001, 5'b11011, 2'b01, 16'h1234, 16'h0FF0, 16'h0000, 2'b00, 4'b1000, 5'b11011, 2'b01, 16'h1234, 16'h0FF0, 16'h0000};
        tbl[3]  = '{4'b0001, 5'b01000, 2'b00, 16'h0001, 16'h0002, 16'h0005, 2'b10, 4'b1100, 5'b01000, 2'b00, 16'h0001, 16'h0002, 16'h0005};
        tbl[4]  = '{4'b0101, 5'b10101, 2'b10, 16'hFFFF, 16'hEEEE, 16'hAAAA, 2'b01, 4'b1100, 5'b01000, 2'b00, 16'h0001, 16'h0002, 16'h0005};
        tbl[5]  = '{4'b0101, 5'b10110, 2'b11, 16'hFFFE, 16'hEEEF, 16'hAAAB, 2'b01, 4'b1100, 5'b01000, 2'b00, 16'h0001, 16'h0002, 16'h0005};
        tbl[6]  = '{4'b0101, 5'b00000, 2'b10, 16'hFFFF, 16'hEEEE, 16'hAAAA, 2'b01, 4'b1100, 5'b01000, 2'b00, 16'h0001, 16'h0002, 16'h0005};
        tbl[7]  = '{4'b0001, 5'b10101, 2'b10, 16'hFFFF, 16'hEEEE, 16'hAAAA, 2'b01, 4'b1010, 5'b10101, 2'b10, 16'hFFFF, 16'hEEEE, 16'hAAAA};
        tbl[8]  = '{4'b0111, 5'b00110, 2'b00, 16'h1357, 16'h2468, 16'h0009, 2'b10, 4'b0000, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[9]  = '{4'b0000, 5'b00110, 2'b11, 16'h1357, 16'h2468, 16'h0009, 2'b10, 4'b0000, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[10] = '{4'b0011, 5'b00000, 2'b00, 16'h0BAD, 16'h0000, 16'h0000, 2'b00, 4'b0000, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[11] = '{4'b0001, 5'b00011, 2'b11, 16'h0042, 16'h0043, 16'h0044, 2'b10, 4'b1100, 5'b00011, 2'b11, 16'h0042, 16'h0043, 16'h0044};
        tbl[12] = '{4'b0001, 5'b00000, 2'b00, 16'h0BAD, 16'h0000, 16'h0000, 2'b00, 4'b1001, 5'b00000, 2'b00, 16'h0BAD, 16'h0000, 16'h0000};
        tbl[13] = '{4'b0001, 5'b10000, 2'b00, 16'h7777, 16'h8888, 16'h0002, 2'b01, 4'b0001, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[14] = '{4'b0001, 5'b10000, 2'b00, 16'h7777, 16'h8888, 16'h0002, 2'b01, 4'b0001, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[15] = '{4'b0101, 5'b10000, 2'b00, 16'h7777, 16'h8888, 16'h0002, 2'b01, 4'b0001, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[16] = '{4'b0011, 5'b10000, 2'b00, 16'h7777, 16'h8888, 16'h0002, 2'b01, 4'b0001, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[17] = '{4'b1001, 5'b10000, 2'b00, 16'h7777, 16'h8888, 16'h0002, 2'b01, 4'b0000, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[18] = '{4'b0101, 5'b00000, 2'b00, 16'h0BAD, 16'h0000, 16'h0000, 2'b00, 4'b0000, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};
        tbl[19] = '{4'b0001, 5'b00000, 2'b00, 16'h0BAD, 16'h0000, 16'h0000, 2'b00, 4'b1001, 5'b00000, 2'b00, 16'h0BAD, 16'h0000, 16'h0000};
        tbl[20] = '{4'b1101, 5'b01010, 2'b01, 16'h9999, 16'h8888, 16'h7777, 2'b11, 4'b0000, 5'b00001, 2'b00, 16'h0000, 16'h0000, 16'h0000};

        for (int i = 0; i < NVEC; i++) begin
            {rst, stall, flush, id_valid} = tbl[i].ctl;
            id_opCode   = tbl[i].opc;
            id_funct    = tbl[i].funct;
            id_rd1      = tbl[i].rd1;
            id_rd2      = tbl[i].rd2;
            id_imm      = tbl[i].imm;
            {id_regWrite, id_memWrite} = tbl[i].wr;
            id_memRead  = 1'b0;
            id_pcInc    = 16'h0100 + 16'(i * 2);
            id_wrReg    = 3'(i);
            step();
            check($sformatf("tbl[%0d]", i),
                  {20'b0, ex_valid, ex_regWrite, ex_memWrite, halted, ex_opCode, ex_funct, ex_rd1, ex_rd2, ex_imm},
                  {20'b0, tbl[i].eFlg, tbl[i].eOpc, tbl[i].eFunct, tbl[i].eRd1, tbl[i].eRd2, tbl[i].eImm});
        end

        // HALT followed by stores: memWrite must never reach EX, halted sticks.
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        step();
        rst = 1'b0; id_valid = 1'b1; id_opCode = 5'b00000;
        step();
        for (int k = 0; k < 6; k++) begin
            randInputs();
            id_valid = 1'b1; id_opCode = 5'b10000; id_memWrite = 1'b1;
            stall = 1'($urandom); flush = 1'($urandom);
            step();
            check($sformatf("haltSeq[%0d]", k), {77'b0, ex_memWrite, halted}, {77'b0, 1'b0, 1'b1});
        end

        for (int k = 0; k < 400; k++) begin
            randInputs();
            rst   = ($urandom_range(0, 39) == 0) || (mHalted && $urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
